// File: rtl/ssy_rr_arb.sv
// Round-robin arbiter: captures per-channel requests, grants one channel for GRANT_CYCLES, then COOLDOWN gap.
// Latency: request sampled at edge t is granted after edge t+1; a channel's request is ignored while its idle is low.
module ssy_rr_arb #(
  parameter int NUM_CH       = 4,
  parameter int GRANT_CYCLES = 2,
  parameter int COOLDOWN     = 1,
  parameter int CW           = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] request,
  output logic [NUM_CH-1:0] idle,
  output logic [NUM_CH-1:0] granted,
  output logic              grant_valid,
  output logic [CW-1:0]     grant_id
);

  localparam int CNT_W = $clog2(GRANT_CYCLES + COOLDOWN + 1);

  typedef enum logic [1:0] {ARB, GRANT, COOL} state_t;

  state_t            state;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] clr_mask;
  logic [NUM_CH-1:0] sel_oh;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     sel_id;
  logic [CW-1:0]     nxt_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              sel_vld;
  logic              grant_done;

  assign idle       = ~pend;
  assign grant_done = (state == GRANT) && (cnt == '0);
  assign nxt_ptr    = (grant_id == CW'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;

  // granted is one-hot on the served channel, so it doubles as the pend clear mask
  always_comb begin
    clr_mask = '0;
    if (grant_done) clr_mask = granted;
  end

  // Scan from the highest offset down so the channel nearest ptr wins
  always_comb begin
    int idx;
    sel_vld = 1'b0;
    sel_id  = '0;
    sel_oh  = '0;
    idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pend[CW'(idx)]) begin
        sel_vld = 1'b1;
        sel_id  = CW'(idx);
      end
    end
    sel_oh[sel_id] = sel_vld;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB;
      pend        <= '0;
      ptr         <= '0;
      cnt         <= '0;
      granted     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      pend <= (pend | (request & idle)) & ~clr_mask;
      case (state)
        ARB: begin
          if (sel_vld) begin
            granted     <= sel_oh;
            grant_valid <= 1'b1;
            grant_id    <= sel_id;
            cnt         <= CNT_W'(GRANT_CYCLES - 1);
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (cnt == '0) begin
            granted     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= nxt_ptr;
            if (COOLDOWN > 0) begin
              cnt   <= CNT_W'(COOLDOWN - 1);
              state <= COOL;
            end else begin
              state <= ARB;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        COOL: begin
          if (cnt == '0) state <= ARB;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_ssy_rr_arb.sv
// Directed bench for ssy_rr_arb: expected grants (channel, start cycle) are queued at stimulus time
// and matched by per-DUT monitors on the falling edge.
module tb_ssy_rr_arb;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic [3:0] idle;
  logic [3:0] granted;
  logic       grant_valid;
  logic [1:0] grant_id;

  logic [2:0] request3;
  logic [2:0] idle3;
  logic [2:0] granted3;
  logic       grant_valid3;
  logic [1:0] grant_id3;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   c;
  exp_t q0[$];
  exp_t q3[$];

  ssy_rr_arb #(.NUM_CH(4), .GRANT_CYCLES(2), .COOLDOWN(1)) dut (
    .clk(clk), .reset(reset), .request(request), .idle(idle),
    .granted(granted), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  ssy_rr_arb #(.NUM_CH(3), .GRANT_CYCLES(1), .COOLDOWN(0)) dut3 (
    .clk(clk), .reset(reset), .request(request3), .idle(idle3),
    .granted(granted3), .grant_valid(grant_valid3), .grant_id(grant_id3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor for the 4-channel instance
  int   run0 = 0;
  int   last0 = 0;
  exp_t e0;
  always @(negedge clk) begin
    if (reset) begin
      run0 = 0;
    end else begin
      check("onehot0", 32'($onehot0(granted)), 1);
      check("vld_or0", grant_valid, |granted);
      if (grant_valid && run0 == 0) begin
        check("sb_pending0", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e0 = q0.pop_front();
          check("gnt_id0", grant_id, e0.id);
          check("gnt_cyc0", cyc, e0.cyc);
          check("gnt_oh0", granted, 32'(1) << e0.id);
        end
        run0  = 1;
        last0 = int'(grant_id);
      end else if (grant_valid) begin
        run0++;
      end else if (run0 != 0) begin
        check("gnt_len0", run0, 2);
        check("idle_back0", idle[last0], 1'b1);
        run0 = 0;
      end
    end
  end

  // Monitor for the 3-channel instance
  int   run3 = 0;
  exp_t e3;
  always @(negedge clk) begin
    if (reset) begin
      run3 = 0;
    end else begin
      check("onehot3", 32'($onehot0(granted3)), 1);
      check("vld_or3", grant_valid3, |granted3);
      if (grant_valid3 && run3 == 0) begin
        check("sb_pending3", q3.size() > 0, 1);
        if (q3.size() > 0) begin
          e3 = q3.pop_front();
          check("gnt_id3", grant_id3, e3.id);
          check("gnt_cyc3", cyc, e3.cyc);
        end
        run3 = 1;
      end else if (grant_valid3) begin
        run3++;
      end else if (run3 != 0) begin
        check("gnt_len3", run3, 1);
        run3 = 0;
      end
    end
  end

  initial begin
    reset    = 1'b1;
    request  = '0;
    request3 = '0;
    repeat (2) @(negedge clk);
    check("rst_idle", idle, 4'b1111);
    check("rst_granted", granted, 4'b0000);
    check("rst_vld", grant_valid, 1'b0);
    check("rst_id", grant_id, 2'd0);
    check("gid3_width", $bits(grant_id3), 2);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Round-robin over all four channels from ptr=0, 4-cycle period
    c = cyc;
    request = 4'b1111;
    for (int i = 0; i < 4; i++) q0.push_back('{i, c + 2 + 4 * i});
    @(negedge clk);
    request = '0;
    check("rr_idle", idle, 4'b0000);
    repeat (18) @(negedge clk);

    // Single request on channel 2
    c = cyc;
    request = 4'b0100;
    q0.push_back('{2, c + 2});
    @(negedge clk);
    request = '0;
    check("single_idle", idle, 4'b1011);
    @(negedge clk);
    check("single_gnt_a", granted, 4'b0100);
    check("single_id", grant_id, 2'd2);
    @(negedge clk);
    check("single_gnt_b", granted, 4'b0100);
    @(negedge clk);
    check("single_gnt_end", granted, 4'b0000);
    check("single_idle_back", idle, 4'b1111);
    repeat (4) @(negedge clk);

    // Pointer wrap: ptr=3, ch3 then ch0 before ch2
    c = cyc;
    request = 4'b1101;
    q0.push_back('{3, c + 2});
    q0.push_back('{0, c + 6});
    q0.push_back('{2, c + 10});
    @(negedge clk);
    request = '0;
    repeat (14) @(negedge clk);

    // Request held on ch1: re-captured only when idle, one grant per 4 cycles
    c = cyc;
    request = 4'b0010;
    for (int i = 0; i < 3; i++) q0.push_back('{1, c + 2 + 4 * i});
    repeat (12) @(negedge clk);
    request = '0;
    repeat (4) @(negedge clk);

    // Reset during second grant cycle with pend=1010
    c = cyc;
    request = 4'b1010;
    q0.push_back('{3, c + 2});
    @(negedge clk);
    request = '0;
    repeat (2) @(negedge clk);
    check("pre_rst_gnt", granted, 4'b1000);
    check("pre_rst_idle", idle, 4'b0101);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_gnt", granted, 4'b0000);
    check("mid_rst_idle", idle, 4'b1111);
    check("mid_rst_vld", grant_valid, 1'b0);
    check("mid_rst_id", grant_id, 2'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    c = cyc;
    request = 4'b1010;
    q0.push_back('{1, c + 2});
    q0.push_back('{3, c + 6});
    @(negedge clk);
    request = '0;
    repeat (12) @(negedge clk);

    // 3-channel, 1-cycle grant, no cooldown: grant every 2 cycles
    c = cyc;
    request3 = 3'b111;
    for (int i = 0; i < 6; i++) q3.push_back('{i % 3, c + 2 + 2 * i});
    repeat (8) @(negedge clk);
    request3 = '0;

    for (int i = 0; i < 100 && (q0.size() != 0 || q3.size() != 0); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("sb_drain0", q0.size(), 0);
    check("sb_drain3", q3.size(), 0);
    check("end_idle0", idle, 4'b1111);
    check("end_idle3", idle3, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
